// File: rtl/video_sync_generator_if.sv
// Pixel timing bundle between the sync generator and video_compositor.
// master: frame_select_request in, timing/position/address outputs out.
interface video_sync_generator_if;
  logic        frame_select_request;
  logic        frame_select_memory;
  logic [16:0] fb_read_address;
  logic        fb_read_enable;
  logic [9:0]  pixel_x_pos;
  logic [9:0]  pixel_y_pos;
  logic        video_hsync;
  logic        video_vsync;
  logic        video_blank_n;
  logic        frame_start;

  modport master (
    input  frame_select_request,
    output frame_select_memory,
    output fb_read_address,
    output fb_read_enable,
    output pixel_x_pos,
    output pixel_y_pos,
    output video_hsync,
    output video_vsync,
    output video_blank_n,
    output frame_start
  );

  modport slave (
    output frame_select_request,
    input  frame_select_memory,
    input  fb_read_address,
    input  fb_read_enable,
    input  pixel_x_pos,
    input  pixel_y_pos,
    input  video_hsync,
    input  video_vsync,
    input  video_blank_n,
    input  frame_start
  );
endinterface

// File: rtl/video_sync_generator.sv
// VGA timing generator with framebuffer read addressing and latency-aligned outputs.
// Ports: clock, reset (sync, active-high), vid (video_sync_generator_if.master).
module video_sync_generator #(
  parameter int MEM_LATENCY = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33
) (
  input logic clock,
  input logic reset,
  video_sync_generator_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DEPTH   = MEM_LATENCY + 1;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        raw_active;
  logic        raw_hsync;
  logic        raw_vsync;
  logic [8:0]  x_half;
  logic [8:0]  y_half;
  logic [16:0] addr_next;
  logic [16:0] addr_q;
  logic        en_q;
  logic        start_q;
  logic        fsel_q;

  logic [9:0]  h_d   [DEPTH];
  logic [9:0]  v_d   [DEPTH];
  logic        hs_d  [DEPTH];
  logic        vs_d  [DEPTH];
  logic        act_d [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  assign raw_active = (h_count < H_VIS) && (v_count < V_VIS);
  assign raw_hsync  = !((h_count >= HS_BEG) && (h_count <= HS_END));
  assign raw_vsync  = !((v_count >= VS_BEG) && (v_count <= VS_END));

  // 320-wide half-resolution framebuffer: y*320 = y*256 + y*64
  assign x_half    = h_count[9:1];
  assign y_half    = v_count[9:1];
  assign addr_next = {y_half, 8'd0}
                   + {2'd0, y_half, 6'd0}
                   + {8'd0, x_half};

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      en_q   <= 1'b0;
    end else begin
      en_q <= raw_active;
      if (raw_active)
        addr_q <= addr_next;
    end
  end

  // Stage 0 sits beside the address register; the remaining
  // MEM_LATENCY stages shadow the framebuffer read pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        h_d[i]   <= '0;
        v_d[i]   <= '0;
        hs_d[i]  <= 1'b1;
        vs_d[i]  <= 1'b1;
        act_d[i] <= 1'b0;
      end
    end else begin
      h_d[0]   <= h_count;
      v_d[0]   <= v_count;
      hs_d[0]  <= raw_hsync;
      vs_d[0]  <= raw_vsync;
      act_d[0] <= raw_active;
      for (int i = 1; i < DEPTH; i++) begin
        h_d[i]   <= h_d[i-1];
        v_d[i]   <= v_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
        act_d[i] <= act_d[i-1];
      end
    end
  end

  // Decoded from the stage feeding the outputs so the pulse lines up
  // with the delayed (0,0). Qualifying with active keeps the all-zero
  // reset contents of the delay line from looking like a frame start.
  always_ff @(posedge clock) begin
    if (reset)
      start_q <= 1'b0;
    else
      start_q <= act_d[DEPTH-2]
              && (h_d[DEPTH-2] == '0)
              && (v_d[DEPTH-2] == '0);
  end

  // Swap only at the top of vertical blanking so a frame never tears.
  always_ff @(posedge clock) begin
    if (reset)
      fsel_q <= 1'b0;
    else if ((h_count == '0) && (v_count == V_VIS))
      fsel_q <= vid.frame_select_request;
  end

  assign vid.frame_select_memory = fsel_q;
  assign vid.fb_read_address     = addr_q;
  assign vid.fb_read_enable      = en_q;
  assign vid.pixel_x_pos         = h_d[DEPTH-1];
  assign vid.pixel_y_pos         = v_d[DEPTH-1];
  assign vid.video_hsync         = hs_d[DEPTH-1];
  assign vid.video_vsync         = vs_d[DEPTH-1];
  assign vid.video_blank_n       = act_d[DEPTH-1];
  assign vid.frame_start         = start_q;
endmodule

// File: tb/tb_video_sync_generator.sv
// Self-checking bench for video_sync_generator: four instances
// (reduced timing at latency 1/2/4, full VGA timing at latency 2).
module tb_video_sync_generator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [4];
  logic        req  [4];
  logic [9:0]  px   [4];
  logic [9:0]  py   [4];
  logic [16:0] addr [4];
  logic        en   [4];
  logic        hs   [4];
  logic        vsy  [4];
  logic        bl   [4];
  logic        fs   [4];
  logic        fsel [4];
  logic [7:0]  dat  [4];
  int          cnt  [4];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int L   = (g == 1) ? 1 : ((g == 2) ? 4 : 2);
    localparam bit BIG = (g == 3);
    video_sync_generator_if ifc ();
    logic [7:0] pipe [4];
    int n;

    video_sync_generator #(
      .MEM_LATENCY (L),
      .H_ACTIVE    (BIG ? 640 : 40),
      .H_FRONT     (BIG ? 16 : 4),
      .H_SYNC      (BIG ? 96 : 6),
      .H_BACK      (BIG ? 48 : 4),
      .V_ACTIVE    (BIG ? 480 : 30),
      .V_FRONT     (BIG ? 10 : 2),
      .V_SYNC      (2),
      .V_BACK      (BIG ? 33 : 3)
    ) u_dut (
      .clock (clk),
      .reset (rst[g]),
      .vid   (ifc)
    );

    assign ifc.frame_select_request = req[g];
    assign px[g]   = ifc.pixel_x_pos;
    assign py[g]   = ifc.pixel_y_pos;
    assign addr[g] = ifc.fb_read_address;
    assign en[g]   = ifc.fb_read_enable;
    assign hs[g]   = ifc.video_hsync;
    assign vsy[g]  = ifc.video_vsync;
    assign bl[g]   = ifc.video_blank_n;
    assign fs[g]   = ifc.frame_start;
    assign fsel[g] = ifc.frame_select_memory;
    assign dat[g]  = pipe[L-1];
    assign cnt[g]  = n;

    // Framebuffer model: L-cycle read returning address[7:0];
    // n counts clock edges seen with reset low.
    always @(posedge clk) begin
      pipe[0] <= ifc.fb_read_address[7:0];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      if (rst[g]) n <= 0;
      else n <= n + 1;
    end
  end

  function automatic int lat(int i);
    return (i == 1) ? 1 : ((i == 2) ? 4 : 2);
  endfunction
  function automatic bit big(int i);
    return i == 3;
  endfunction
  function automatic int p_ha(int i);  return big(i) ? 640 : 40; endfunction
  function automatic int p_hf(int i);  return big(i) ? 16 : 4;   endfunction
  function automatic int p_hsw(int i); return big(i) ? 96 : 6;   endfunction
  function automatic int p_hb(int i);  return big(i) ? 48 : 4;   endfunction
  function automatic int p_va(int i);  return big(i) ? 480 : 30; endfunction
  function automatic int p_vf(int i);  return big(i) ? 10 : 2;   endfunction
  function automatic int p_vsw(int i); return 2;                 endfunction
  function automatic int p_vb(int i);  return big(i) ? 33 : 3;   endfunction
  function automatic int p_ht(int i);
    return p_ha(i) + p_hf(i) + p_hsw(i) + p_hb(i);
  endfunction
  function automatic int p_vt(int i);
    return p_va(i) + p_vf(i) + p_vsw(i) + p_vb(i);
  endfunction
  function automatic int p_fr(int i);
    return p_ht(i) * p_vt(i);
  endfunction
  function automatic int fb_addr(int x, int y);
    return (y / 2) * 320 + x / 2;
  endfunction

  // Outputs after n post-reset edges show raw position n-(L+1).
  // f = {blank_n, hsync, vsync, frame_start}
  function automatic void model_out(input int i, input int n,
                                    output int x, output int y,
                                    output logic [3:0] f);
    int p;
    if (n < lat(i) + 1) begin
      x = 0;
      y = 0;
      f = 4'b0110;
    end else begin
      p = (n - lat(i) - 1) % p_fr(i);
      x = p % p_ht(i);
      y = p / p_ht(i);
      f[3] = (x < p_ha(i)) && (y < p_va(i));
      f[2] = !((x >= p_ha(i) + p_hf(i)) &&
               (x < p_ha(i) + p_hf(i) + p_hsw(i)));
      f[1] = !((y >= p_va(i) + p_vf(i)) &&
               (y < p_va(i) + p_vf(i) + p_vsw(i)));
      f[0] = (x == 0) && (y == 0);
    end
  endfunction

  // Address register holds the most recent active raw position seen.
  function automatic void model_addr(input int i, input int n,
                                     output logic e, output int a);
    int m, rx, ry;
    if (n == 0) begin
      e = 1'b0;
      a = 0;
    end else begin
      m  = (n - 1) % p_fr(i);
      rx = m % p_ht(i);
      ry = m / p_ht(i);
      e  = (rx < p_ha(i)) && (ry < p_va(i));
      if (ry >= p_va(i)) begin
        rx = p_ha(i) - 1;
        ry = p_va(i) - 1;
      end else if (rx >= p_ha(i)) begin
        rx = p_ha(i) - 1;
      end
      a = fb_addr(rx, ry);
    end
  endfunction

  task automatic test_reset(input int i);
    logic [42:0] got;
    logic [42:0] want;
    logic [1:0]  g2;
    logic [1:0]  w2;
    rst[i] = 1'b1;
    repeat (2) @(negedge clk);
    got  = {px[i], py[i], bl[i], hs[i], vsy[i], fs[i],
            en[i], addr[i], fsel[i]};
    want = {20'd0, 4'b0110, 1'b0, 17'd0, 1'b0};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL reset_values dut%0d got %h want %h", i, got, want);
    end
    rst[i] = 1'b0;
    for (int k = 1; k <= lat(i) + 2; k++) begin
      @(negedge clk);
      g2 = {bl[i], fs[i]};
      w2 = {k >= lat(i) + 1, k == lat(i) + 1};
      tests++;
      if (g2 !== w2) begin
        fails++;
        $display("FAIL release_blank_fs dut%0d clk%0d got %b want %b",
                 i, k, g2, w2);
      end
      if (k <= lat(i) + 1) begin
        tests++;
        if ({px[i], py[i]} !== 20'd0) begin
          fails++;
          $display("FAIL release_pos dut%0d clk%0d got %0d,%0d want 0,0",
                   i, k, px[i], py[i]);
        end
      end
    end
  endtask

  task automatic test_frame(input int i);
    int x, y, ea, n, per, nbl, nhs, nvs;
    logic e;
    logic [3:0] f;
    bit ok;
    ok  = 1'b1;
    nbl = 0;
    nhs = 0;
    nvs = 0;
    for (int k = 0; k <= p_fr(i) + 8 && fs[i] !== 1'b1; k++)
      @(negedge clk);
    tests++;
    if (fs[i] !== 1'b1) begin
      fails++;
      $display("FAIL frame_start_timeout dut%0d got %b want 1", i, fs[i]);
      return;
    end
    for (per = 1; per <= p_fr(i) + 1; per++) begin
      n = cnt[i];
      model_out(i, n, x, y, f);
      model_addr(i, n, e, ea);
      if (ok) begin
        tests++;
        if ({px[i], py[i], bl[i], hs[i], vsy[i], fs[i]} !==
            {10'(x), 10'(y), f}) begin
          fails++;
          ok = 1'b0;
          $display("FAIL timing dut%0d n=%0d got %0d,%0d,%b%b%b%b want %0d,%0d,%b",
                   i, n, px[i], py[i], bl[i], hs[i], vsy[i], fs[i], x, y, f);
        end
        tests++;
        if ({en[i], addr[i]} !== {e, 17'(ea)}) begin
          fails++;
          ok = 1'b0;
          $display("FAIL address dut%0d n=%0d got %b,%0d want %b,%0d",
                   i, n, en[i], addr[i], e, ea);
        end
        if (bl[i] === 1'b1) begin
          tests++;
          if (dat[i] !== 8'(fb_addr(x, y))) begin
            fails++;
            ok = 1'b0;
            $display("FAIL align_data dut%0d pos %0d,%0d got %h want %h",
                     i, x, y, dat[i], 8'(fb_addr(x, y)));
          end
        end
      end
      nbl += (bl[i] === 1'b1) ? 1 : 0;
      nhs += (hs[i] === 1'b0) ? 1 : 0;
      nvs += (vsy[i] === 1'b0) ? 1 : 0;
      @(negedge clk);
      if (fs[i] === 1'b1) break;
    end
    tests++;
    if (per !== p_fr(i)) begin
      fails++;
      $display("FAIL frame_period dut%0d got %0d want %0d", i, per, p_fr(i));
    end
    tests++;
    if (nbl !== p_ha(i) * p_va(i)) begin
      fails++;
      $display("FAIL blank_count dut%0d got %0d want %0d",
               i, nbl, p_ha(i) * p_va(i));
    end
    tests++;
    if (nhs !== p_hsw(i) * p_vt(i)) begin
      fails++;
      $display("FAIL hsync_count dut%0d got %0d want %0d",
               i, nhs, p_hsw(i) * p_vt(i));
    end
    tests++;
    if (nvs !== p_vsw(i) * p_ht(i)) begin
      fails++;
      $display("FAIL vsync_count dut%0d got %0d want %0d",
               i, nvs, p_vsw(i) * p_ht(i));
    end
  endtask

  task automatic test_frame_select(input int i);
    int n, rx, ry, fr;
    logic exp_sel;
    rst[i] = 1'b1;
    req[i] = 1'b1;
    repeat (2) @(negedge clk);
    rst[i] = 1'b0;
    exp_sel = 1'b0;
    for (int k = 0; k < 2 * p_fr(i) + 10; k++) begin
      n  = cnt[i];
      rx = n % p_ht(i);
      ry = (n / p_ht(i)) % p_vt(i);
      fr = n / p_fr(i);
      tests++;
      if (fsel[i] !== exp_sel) begin
        fails++;
        $display("FAIL frame_select dut%0d n=%0d got %b want %b",
                 i, n, fsel[i], exp_sel);
      end
      if (rx == 0 && ry == 10) req[i] = ~req[i];
      if (rx == 0 && ry == 20)
        req[i] = (fr == 0) ? ~req[i] : 1'($urandom);
      if (rx == 0 && ry == p_va(i)) exp_sel = req[i];
      @(negedge clk);
    end
  endtask

  task automatic test_midframe_reset(input int i);
    int target;
    logic [42:0] got;
    logic [42:0] want;
    logic [1:0] g2;
    logic [1:0] w2;
    target = 15 * p_ht(i) + 20;
    for (int k = 0; k < p_fr(i) + 2 && (cnt[i] % p_fr(i)) != target; k++)
      @(negedge clk);
    tests++;
    if ((cnt[i] % p_fr(i)) != target) begin
      fails++;
      $display("FAIL midreset_reach dut%0d got %0d want %0d",
               i, cnt[i] % p_fr(i), target);
      return;
    end
    rst[i] = 1'b1;
    @(negedge clk);
    got  = {px[i], py[i], bl[i], hs[i], vsy[i], fs[i],
            en[i], addr[i], fsel[i]};
    want = {20'd0, 4'b0110, 1'b0, 17'd0, 1'b0};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL midreset_values dut%0d got %h want %h", i, got, want);
    end
    rst[i] = 1'b0;
    for (int k = 1; k <= lat(i) + 1; k++) begin
      @(negedge clk);
      g2 = {bl[i], fs[i]};
      w2 = {k == lat(i) + 1, k == lat(i) + 1};
      tests++;
      if (g2 !== w2 || {px[i], py[i]} !== 20'd0) begin
        fails++;
        $display("FAIL midreset_resume dut%0d clk%0d got %b,%0d,%0d want %b,0,0",
                 i, k, g2, px[i], py[i], w2);
      end
    end
  endtask

  task automatic test_default(input int i);
    int x, y, n, nhs, first_low;
    logic [3:0] f;
    bit ok, seen;
    ok        = 1'b1;
    seen      = 1'b0;
    nhs       = 0;
    first_low = -1;
    rst[i] = 1'b1;
    repeat (2) @(negedge clk);
    rst[i] = 1'b0;
    for (int k = 0; k < 2 * p_ht(i) + lat(i) + 3; k++) begin
      n = cnt[i];
      model_out(i, n, x, y, f);
      if (ok) begin
        tests++;
        if ({px[i], py[i], bl[i], hs[i], vsy[i], fs[i]} !==
            {10'(x), 10'(y), f}) begin
          fails++;
          ok = 1'b0;
          $display("FAIL vga_timing n=%0d got %0d,%0d,%b%b%b%b want %0d,%0d,%b",
                   n, px[i], py[i], bl[i], hs[i], vsy[i], fs[i], x, y, f);
        end
      end
      if (px[i] == 10'd3 && py[i] == 10'd1 && bl[i] === 1'b1) begin
        seen = 1'b1;
        tests++;
        if (dat[i] !== 8'h01) begin
          fails++;
          $display("FAIL vga_data_x3y1 got %h want 01", dat[i]);
        end
      end
      if (py[i] == 10'd0 && hs[i] === 1'b0) begin
        if (first_low < 0) first_low = int'(px[i]);
        nhs++;
      end
      @(negedge clk);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL vga_x3y1_reached got 0 want 1");
    end
    tests++;
    if (nhs !== 96 || first_low !== 656) begin
      fails++;
      $display("FAIL vga_hsync_line0 got %0d from x=%0d want 96 from x=656",
               nhs, first_low);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      req[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) test_reset(i);
    test_frame(0);
    test_frame(1);
    test_frame(2);
    test_frame_select(0);
    test_midframe_reset(0);
    test_frame(0);
    test_default(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
